// File: rtl/rct_m2w_pipe_bridge_if.sv
// Bundles the mem-if request/response channels and the Wishbone classic master port.
// The slave modport is the bridge's view; the master modport is the surrounding core/fabric's view.
interface rct_m2w_pipe_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = DATA_W / 8,
    parameter int TID_W  = 16
);
    // Both mem-if channels are valid/ready: a beat transfers on a rising edge
    // where valid and ready are both high, and a valid beat holds its fields
    // stable until that edge.
    logic              mem_if_req_valid;
    logic              mem_if_req_ready;
    logic [2:0]        mem_if_req_type;
    logic [TID_W-1:0]  mem_if_req_tid;
    logic [ADDR_W-1:0] mem_if_req_addr;
    logic [MASK_W-1:0] mem_if_req_mask;
    logic [DATA_W-1:0] mem_if_req_data;

    logic              mem_if_resp_valid;
    logic              mem_if_resp_ready;
    logic [2:0]        mem_if_resp_type;
    logic [TID_W-1:0]  mem_if_resp_tid;
    logic [DATA_W-1:0] mem_if_resp_data;

    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_addr_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [MASK_W-1:0] wb_sel_o;
    logic              wb_ack_i;
    logic              wb_err_i;
    logic [DATA_W-1:0] wb_data_i;

    logic              dbg_bus;

    modport slave (
        input  mem_if_req_valid, mem_if_req_type, mem_if_req_tid, mem_if_req_addr,
        input  mem_if_req_mask, mem_if_req_data, mem_if_resp_ready,
        output mem_if_req_ready, mem_if_resp_valid, mem_if_resp_type, mem_if_resp_tid,
        output mem_if_resp_data,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o,
        input  wb_ack_i, wb_err_i, wb_data_i,
        output dbg_bus
    );

    modport master (
        output mem_if_req_valid, mem_if_req_type, mem_if_req_tid, mem_if_req_addr,
        output mem_if_req_mask, mem_if_req_data, mem_if_resp_ready,
        input  mem_if_req_ready, mem_if_resp_valid, mem_if_resp_type, mem_if_resp_tid,
        input  mem_if_resp_data,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o,
        output wb_ack_i, wb_err_i, wb_data_i,
        input  dbg_bus
    );
endinterface

// File: rtl/rct_m2w_pipe_bridge.sv
// Queued mem-if to Wishbone classic bridge: request FIFO -> one bus cycle at a time -> response FIFO.
// Optional bus timeout is built when M2W_TIMEOUT_EN is defined.
module rct_m2w_pipe_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MASK_W         = DATA_W / 8,
    parameter int TID_W          = 16,
    parameter int REQ_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                  clk_i,
    input logic                  rstn_i,
    rct_m2w_pipe_bridge_if.slave bus
);
    localparam int RQ_AW = $clog2(REQ_DEPTH);
    localparam int RS_AW = $clog2(RSP_DEPTH);
    localparam int REQ_W = 1 + TID_W + ADDR_W + MASK_W + DATA_W;
    localparam int RSP_W = 3 + TID_W + DATA_W;
    localparam logic [RQ_AW:0] REQ_CNT_FULL = (RQ_AW + 1)'(REQ_DEPTH);
    localparam logic [RS_AW:0] RSP_CNT_FULL = (RS_AW + 1)'(RSP_DEPTH);

    if ((REQ_DEPTH < 2) || ((1 << RQ_AW) != REQ_DEPTH) ||
        (RSP_DEPTH < 2) || ((1 << RS_AW) != RSP_DEPTH) || (TIMEOUT_CYCLES < 2)) begin : g_param_chk
        $error("rct_m2w_pipe_bridge: depths must be powers of 2 >= 2, TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic {S_IDLE = 1'b0, S_BUS = 1'b1} state_e;

    // ---------------- request FIFO ----------------
    logic [REQ_W-1:0] req_mem_q [REQ_DEPTH];
    logic [RQ_AW-1:0] req_wp_q, req_rp_q;
    logic [RQ_AW:0]   req_cnt_q;
    logic             ready_en_q;
    logic             req_ready, req_push, req_pop;
    logic [REQ_W-1:0] req_head;

    assign req_ready = ready_en_q && (req_cnt_q != REQ_CNT_FULL);
    assign req_push  = bus.mem_if_req_valid && req_ready;
    assign req_head  = req_mem_q[req_rp_q];
    assign bus.mem_if_req_ready = req_ready;

    always_ff @(posedge clk_i) begin
        if (req_push) begin
            req_mem_q[req_wp_q] <= {(bus.mem_if_req_type == 3'd1), bus.mem_if_req_tid,
                                    bus.mem_if_req_addr, bus.mem_if_req_mask, bus.mem_if_req_data};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            req_wp_q   <= '0;
            req_rp_q   <= '0;
            req_cnt_q  <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (req_push) req_wp_q <= req_wp_q + RQ_AW'(1);
            if (req_pop)  req_rp_q <= req_rp_q + RQ_AW'(1);
            case ({req_push, req_pop})
                2'b10:   req_cnt_q <= req_cnt_q + (RQ_AW + 1)'(1);
                2'b01:   req_cnt_q <= req_cnt_q - (RQ_AW + 1)'(1);
                default: req_cnt_q <= req_cnt_q;
            endcase
        end
    end

    // ---------------- response FIFO ----------------
    logic [RSP_W-1:0] rsp_mem_q [RSP_DEPTH];
    logic [RS_AW-1:0] rsp_wp_q, rsp_rp_q;
    logic [RS_AW:0]   rsp_cnt_q;
    logic             rsp_push, rsp_pop, rsp_full;
    logic [RSP_W-1:0] rsp_wdata;

    assign rsp_full = (rsp_cnt_q == RSP_CNT_FULL);
    assign bus.mem_if_resp_valid = (rsp_cnt_q != '0);
    assign rsp_pop  = bus.mem_if_resp_valid && bus.mem_if_resp_ready;
    assign {bus.mem_if_resp_type, bus.mem_if_resp_tid, bus.mem_if_resp_data} = rsp_mem_q[rsp_rp_q];

    always_ff @(posedge clk_i) begin
        if (rsp_push) rsp_mem_q[rsp_wp_q] <= rsp_wdata;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rsp_wp_q  <= '0;
            rsp_rp_q  <= '0;
            rsp_cnt_q <= '0;
        end else begin
            if (rsp_push) rsp_wp_q <= rsp_wp_q + RS_AW'(1);
            if (rsp_pop)  rsp_rp_q <= rsp_rp_q + RS_AW'(1);
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_cnt_q <= rsp_cnt_q + (RS_AW + 1)'(1);
                2'b01:   rsp_cnt_q <= rsp_cnt_q - (RS_AW + 1)'(1);
                default: rsp_cnt_q <= rsp_cnt_q;
            endcase
        end
    end

    // ---------------- bus FSM ----------------
    state_e            state_q, state_d;
    logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] sel_q, sel_d;
    logic [TID_W-1:0]  tid_q, tid_d;
    logic              launch, timeout, bus_done;
    logic [2:0]        rsp_type;
    logic [DATA_W-1:0] rsp_data;

    // Launch only when the response slot is already guaranteed.
    assign launch   = (req_cnt_q != '0) && !rsp_full;
    assign bus_done = bus.wb_ack_i || bus.wb_err_i || timeout;

`ifdef M2W_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0] to_cnt_q;

    assign timeout = (state_q == S_BUS) && !bus.wb_ack_i && !bus.wb_err_i &&
                     (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                to_cnt_q <= '0;
        else if (state_q == S_IDLE) to_cnt_q <= '0;
        else                        to_cnt_q <= to_cnt_q + TO_W'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            tid_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            tid_q   <= tid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch)   state_d = S_BUS;
            S_BUS:   if (bus_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_pop  = 1'b0;
        rsp_push = 1'b0;
        rsp_type = 3'd0;
        rsp_data = '0;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        tid_d    = tid_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    req_pop = 1'b1;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = req_head[REQ_W-1];
                    tid_d   = req_head[ADDR_W+MASK_W+DATA_W +: TID_W];
                    addr_d  = req_head[MASK_W+DATA_W +: ADDR_W];
                    sel_d   = req_head[DATA_W +: MASK_W];
                    wdata_d = req_head[DATA_W-1:0];
                end
            end
            S_BUS: begin
                if (bus_done) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    we_d     = 1'b0;
                    rsp_push = 1'b1;
                    // Error (or timeout) outranks a simultaneous ack.
                    if (bus.wb_err_i || timeout) rsp_type = 3'd2;
                    else if (we_q)               rsp_type = 3'd1;
                    else                         rsp_type = 3'd0;
                    if (bus.wb_ack_i && !bus.wb_err_i && !we_q) rsp_data = bus.wb_data_i;
                end
            end
            default: ;
        endcase
    end

    assign rsp_wdata = {rsp_type, tid_q, rsp_data};

    assign bus.wb_cyc_o  = cyc_q;
    assign bus.wb_stb_o  = stb_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_addr_o = addr_q;
    assign bus.wb_data_o = wdata_q;
    assign bus.wb_sel_o  = sel_q;
    assign bus.dbg_bus   = (state_q == S_BUS);
endmodule
